// File: rtl/frame_pack_wr.sv
`default_nettype none
// ============================================================================
// Module      : frame_pack_wr
// Description : Frame-aligned pixel packer for the DDR write port. It packs
//               PIX_W-bit pixels into DATA_W-bit words and checks the
//               geometry of each frame. Optional feature macro:
//               FRAME_PACK_SKIP_EN adds the frame_skip input.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_pack_wr #(
    parameter int H_PIXEL = 640,
    parameter int V_PIXEL = 480,
    parameter int PIX_W   = 1,
    parameter int DATA_W  = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              enable,
    input  logic              pre_vsync,
    input  logic              pre_de,
    input  logic [PIX_W-1:0]  pre_pix,
`ifdef FRAME_PACK_SKIP_EN
    input  logic [3:0]        frame_skip,
`endif
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_rst,
    output logic              frame_done,
    output logic              frame_err,
    output logic [11:0]       line_cnt
);

    localparam int              c_ppw       = DATA_W / PIX_W;
    localparam int              c_pcw       = (c_ppw > 1) ? $clog2(c_ppw) : 1;
    localparam logic [c_pcw-1:0] c_ppw_last = c_pcw'(c_ppw - 1);
    localparam logic [c_pcw-1:0] c_pix_one  = c_pcw'(1);
    localparam logic [11:0]     c_h         = 12'(H_PIXEL);
    localparam logic [11:0]     c_v         = 12'(V_PIXEL);
    localparam logic [0:0]      c_st_idle   = 1'b0;
    localparam logic [0:0]      c_st_active = 1'b1;

    logic [0:0]        r_state, w_state_nxt;
    logic              r_vsync_d, r_de_d;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic [c_pcw-1:0]  r_pix_cnt, w_pix_cnt_nxt;
    logic [11:0]       r_x_cnt, w_x_cnt_nxt;
    logic [11:0]       r_line_cnt, w_line_cnt_nxt;
    logic              r_frame_err, w_err_nxt;
    logic              r_wr_en, w_wr_en_nxt;
    logic [DATA_W-1:0] r_wr_data, w_wr_data_nxt;
    logic              r_wr_rst, w_wr_rst_nxt;
    logic              r_done, w_done_nxt;
    logic              r_writing, w_writing_nxt;
    logic              w_take;
    logic              w_fb;
    logic              w_line_end;
`ifdef FRAME_PACK_SKIP_EN
    logic [3:0]        r_skip_cnt, w_skip_nxt;
`endif

    assign w_fb       = pre_vsync & ~r_vsync_d;
    assign w_line_end = r_de_d & ~pre_de;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= c_st_idle;
            r_vsync_d   <= 1'b0;
            r_de_d      <= 1'b0;
            r_shift     <= '0;
            r_pix_cnt   <= '0;
            r_x_cnt     <= '0;
            r_line_cnt  <= '0;
            r_frame_err <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_wr_rst    <= 1'b0;
            r_done      <= 1'b0;
            r_writing   <= 1'b0;
`ifdef FRAME_PACK_SKIP_EN
            r_skip_cnt  <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_vsync_d   <= pre_vsync;
            r_de_d      <= pre_de;
            r_shift     <= w_shift_nxt;
            r_pix_cnt   <= w_pix_cnt_nxt;
            r_x_cnt     <= w_x_cnt_nxt;
            r_line_cnt  <= w_line_cnt_nxt;
            r_frame_err <= w_err_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_wr_rst    <= w_wr_rst_nxt;
            r_done      <= w_done_nxt;
            r_writing   <= w_writing_nxt;
`ifdef FRAME_PACK_SKIP_EN
            r_skip_cnt  <= w_skip_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_pix_cnt_nxt  = r_pix_cnt;
        w_x_cnt_nxt    = r_x_cnt;
        w_line_cnt_nxt = r_line_cnt;
        w_err_nxt      = r_frame_err;
        w_wr_en_nxt    = 1'b0;
        w_wr_data_nxt  = r_wr_data;
        w_wr_rst_nxt   = 1'b0;
        w_done_nxt     = 1'b0;
        w_writing_nxt  = r_writing;
        w_take         = 1'b0;
`ifdef FRAME_PACK_SKIP_EN
        w_skip_nxt     = r_skip_cnt;
`endif
        if (r_state == c_st_active) begin
            // Lines beyond V_PIXEL are dropped, so they are not counted either.
            if (w_line_end) begin
                if (r_line_cnt < c_v) begin
                    if (r_writing && (r_x_cnt != c_h)) begin
                        w_err_nxt = 1'b1;
                    end
                    w_line_cnt_nxt = r_line_cnt + 12'd1;
                end
                w_x_cnt_nxt = '0;
            end
            if (w_fb) begin
                w_done_nxt = 1'b1;
                if (r_writing && ((w_line_cnt_nxt != c_v) || (r_pix_cnt != '0))) begin
                    w_err_nxt = 1'b1;
                end
                w_line_cnt_nxt = '0;
                w_x_cnt_nxt    = '0;
                w_pix_cnt_nxt  = '0;
                w_shift_nxt    = '0;
                if (enable) begin
`ifdef FRAME_PACK_SKIP_EN
                    if (r_writing) begin
                        w_skip_nxt = frame_skip;
                    end else if (r_skip_cnt != 4'd0) begin
                        w_skip_nxt = r_skip_cnt - 4'd1;
                    end
                    w_writing_nxt = (w_skip_nxt == 4'd0);
`else
                    w_writing_nxt = 1'b1;
`endif
                    w_wr_rst_nxt = w_writing_nxt;
                    w_take       = 1'b1;
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end else begin
                w_take = 1'b1;
            end
        end else if (w_fb && enable) begin
            w_state_nxt   = c_st_active;
            w_wr_rst_nxt  = 1'b1;
            w_writing_nxt = 1'b1;
            w_take        = 1'b1;
`ifdef FRAME_PACK_SKIP_EN
            w_skip_nxt    = 4'd0;
`endif
        end

        if (w_wr_rst_nxt) begin
            w_err_nxt = 1'b0;
        end

        // A pixel in the boundary cycle is the first pixel of the new frame.
        if (w_take && pre_de && w_writing_nxt) begin
            if (w_line_cnt_nxt >= c_v) begin
                w_err_nxt = 1'b1;
            end else begin
                w_x_cnt_nxt = w_x_cnt_nxt + 12'd1;
                w_shift_nxt = (w_shift_nxt << PIX_W) | DATA_W'(pre_pix);
                if (w_pix_cnt_nxt == c_ppw_last) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_data_nxt = w_shift_nxt;
                    w_pix_cnt_nxt = '0;
                end else begin
                    w_pix_cnt_nxt = w_pix_cnt_nxt + c_pix_one;
                end
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_data    = r_wr_data;
    assign wr_rst     = r_wr_rst;
    assign frame_done = r_done;
    assign frame_err  = r_frame_err;
    assign line_cnt   = r_line_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_pack_wr.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_pack_wr
// Description : Scoreboard bench for frame_pack_wr with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_pack_wr;

    localparam int H  = 16;
    localparam int V  = 2;
    localparam int PW = 1;
    localparam int DW = 16;

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          enable    = 1'b0;
    logic          pre_vsync = 1'b0;
    logic          pre_de    = 1'b0;
    logic [PW-1:0] pre_pix   = '0;
`ifdef FRAME_PACK_SKIP_EN
    logic [3:0]    frame_skip = 4'd0;
`endif
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          wr_rst;
    logic          frame_done;
    logic          frame_err;
    logic [11:0]   line_cnt;

    frame_pack_wr #(.H_PIXEL(H), .V_PIXEL(V), .PIX_W(PW), .DATA_W(DW)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .enable     (enable),
        .pre_vsync  (pre_vsync),
        .pre_de     (pre_de),
        .pre_pix    (pre_pix),
`ifdef FRAME_PACK_SKIP_EN
        .frame_skip (frame_skip),
`endif
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_rst     (wr_rst),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .line_cnt   (line_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int errors = 0, checks = 0;
    int act_rst = 0, act_done = 0, exp_rst = 0, exp_done = 0;

    // Frame-level reference state
    bit            m_open = 0, m_writing = 0, m_prev_de = 0;
    int            m_lines = 0, m_npix = 0, m_skip = 0;
    logic [DW-1:0] m_acc = '0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (wr_rst) act_rst++;
            if (frame_done) act_done++;
            if (wr_en) begin
                if (sb.size() == 0) begin
                    check("unexpected_wr_en", 1, 0);
                end else begin
                    m_e = sb.pop_front();
                    check("wr_data", wr_data, m_e.data);
                    check("wr_latency", cyc, m_e.cyc);
                end
            end
        end
    end

    task automatic model_line_end();
        if (m_open && m_prev_de && m_lines < V) m_lines++;
    endtask

    task automatic pix(input bit de, input logic [PW-1:0] px);
        @(negedge sys_clk);
        pre_vsync = 1'b0;
        pre_de    = de;
        pre_pix   = px;
        if (!de) model_line_end();
        if (de && m_open && m_writing && m_lines < V) begin
            m_acc = (m_acc << PW) | DW'(px);
            m_npix++;
            if (m_npix == DW / PW) begin
                sb.push_back('{data: m_acc, cyc: cyc + 1});
                m_npix = 0;
            end
        end
        m_prev_de = de;
    endtask

    task automatic fb(input bit en);
        @(negedge sys_clk);
        enable    = en;
        pre_vsync = 1'b1;
        pre_de    = 1'b0;
        model_line_end();
        m_prev_de = 0;
        if (m_open) begin
            exp_done++;
            if (en) begin
`ifdef FRAME_PACK_SKIP_EN
                if (m_writing) m_skip = frame_skip;
                else if (m_skip > 0) m_skip--;
                m_writing = (m_skip == 0);
`else
                m_writing = 1;
`endif
                if (m_writing) exp_rst++;
            end else begin
                m_open = 0;
            end
        end else if (en) begin
            m_open = 1; m_writing = 1; m_skip = 0; exp_rst++;
        end
        m_lines = 0; m_npix = 0; m_acc = '0;
        pix(1'b0, '0);
    endtask

    task automatic line(input int n, input bit alt);
        logic [PW-1:0] v;
        for (int i = 0; i < n; i++) begin
            if (alt) v = ((i % 2) == 0) ? '1 : '0;
            else     v = PW'($urandom);
            pix(1'b1, v);
        end
        pix(1'b0, '0);
        repeat ($urandom_range(1, 3)) pix(1'b0, '0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_wr_rst"}, wr_rst, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_line_cnt"}, line_cnt, 0);
    endtask

    task automatic check_counts(input string tag);
        repeat (3) pix(1'b0, '0);
        check({tag, "_wr_rst_count"}, act_rst, exp_rst);
        check({tag, "_frame_done_count"}, act_done, exp_done);
        check({tag, "_words_pending"}, sb.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        check_outputs_zero("reset");
        sys_rst_n = 1'b1;

        // Pixels before any frame boundary are dropped, then a full random frame.
        line(H, 0);
        line(H, 0);
        check_counts("pre_fb");
        fb(1);
        line(H, 0);
        line(H, 0);
        fb(1);
        check_counts("random_frame");

        // Alternating pattern frame: both words should be 16'hAAAA.
        line(H, 1);
        line(H, 1);
        check("alt_line_cnt", line_cnt, V);
        check("alt_frame_err", frame_err, 0);
        fb(1);
        check_counts("alt_frame");
        check("alt_err_after", frame_err, 0);

        // Short second line: sticky error until the next write-address reset.
        line(H, 0);
        line(10, 0);
        check("short_err_set", frame_err, 1);
        pix(1'b0, '0);
        check("short_err_held", frame_err, 1);
        fb(1);
        pix(1'b0, '0);
        check("short_err_cleared", frame_err, 0);
        check_counts("short_frame");

        // Enable dropped mid-frame: frame completes, then nothing more is written.
        line(H, 0);
        enable = 1'b0;
        line(H, 0);
        fb(0);
        check_counts("enable_drop");
        line(H, 0);
        fb(0);
        line(H, 0);
        fb(0);
        check_counts("idle_frame");

        // Asynchronous reset in the middle of a line.
        fb(1);
        for (int i = 0; i < 8; i++) pix(1'b1, PW'($urandom));
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        pre_de = 1'b0;
        #1 check_outputs_zero("async_reset");
        m_open = 0; m_npix = 0; m_acc = '0; m_prev_de = 0; m_lines = 0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        line(H, 0);
        line(H, 0);
        check_counts("post_reset_no_fb");
        fb(1);
        line(H, 0);
        line(H, 0);
        fb(0);
        check_counts("post_reset_frame");

`ifdef FRAME_PACK_SKIP_EN
        frame_skip = 4'd2;
        fb(1);
        for (int f = 0; f < 6; f++) begin
            line(H, 0);
            line(H, 0);
            fb(f < 5);
        end
        check_counts("skip_frames");
`endif

        repeat (4) @(negedge sys_clk);
        check("final_scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
